// File: rtl/button_click_decoder.sv
// Decodes single/double/triple clicks from a debounced click pulse stream.
// A sequence closes when WINDOW cycles pass without a click, or on the third click.
module button_click_decoder #(
  parameter logic [31:0] WINDOW = 32'd25_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pulse,
  output logic       o_single,
  output logic       o_double,
  output logic       o_triple,
  output logic [1:0] o_code,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_e;

  localparam logic [31:0] LAST = WINDOW - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        single_q, single_d;
  logic        double_q, double_d;
  logic        triple_q, triple_d;
  logic [1:0]  code_q, code_d;

  // State, window counter and registered decode outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      triple_q <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      triple_q <= triple_d;
      code_q   <= code_d;
    end
  end

  // Next-state logic; a click always wins over an expiring window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    triple_d = 1'b0;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (i_pulse) begin
          state_d = ONE;
        end else begin
          state_d = IDLE;
        end
      end
      ONE: begin
        if (i_pulse) begin
          state_d = TWO;
          cnt_d   = 32'd0;
        end else if (cnt_q == LAST) begin
          state_d  = IDLE;
          cnt_d    = 32'd0;
          single_d = 1'b1;
          code_d   = 2'b01;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      TWO: begin
        if (i_pulse) begin
          state_d  = IDLE;
          cnt_d    = 32'd0;
          triple_d = 1'b1;
          code_d   = 2'b11;
        end else if (cnt_q == LAST) begin
          state_d  = IDLE;
          cnt_d    = 32'd0;
          double_d = 1'b1;
          code_d   = 2'b10;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  assign o_single = single_q;
  assign o_double = double_q;
  assign o_triple = triple_q;
  assign o_code   = code_q;
  assign o_busy   = (state_q == ONE) || (state_q == TWO);

endmodule

// File: doc/button_click_decoder.md
BUTTON_CLICK_DECODER -- requirements
Module: button_click_decoder

Interface
REQ-001 Parameter WINDOW, default 25_000_000, meaning the click window in i_clk cycles (500 ms at 50 MHz); legal range 2..2^32-1.
REQ-002 i_clk  input  1  system clock; all state changes on rising edge.
REQ-003 i_reset  input  1  reset, asynchronous, active-high.
REQ-004 i_pulse  input  1  single-cycle debounced click pulse, one per button release, synchronous to i_clk.
REQ-005 o_single  output  1  one-cycle pulse: single click decoded.
REQ-006 o_double  output  1  one-cycle pulse: double click decoded.
REQ-007 o_triple  output  1  one-cycle pulse: triple click decoded.
REQ-008 o_code  output  2  last decoded event, held: 00 none, 01 single, 10 double, 11 triple.
REQ-009 o_busy  output  1  high while a click sequence is open (state ONE or TWO).

Function
REQ-010 FSM SHALL have exactly three states: IDLE, ONE, TWO.
REQ-011 Window counter SHALL be 32-bit unsigned, no wrap: it never exceeds WINDOW-1.
REQ-012 IDLE, i_pulse=1: go to ONE, counter <= 0.
REQ-013 ONE, i_pulse=1: go to TWO, counter <= 0 (window restarts from each click).
REQ-014 TWO, i_pulse=1: go to IDLE, assert o_triple for one cycle, o_code <= 11, counter <= 0.
REQ-015 ONE or TWO, i_pulse=0, counter < WINDOW-1: counter <= counter+1, state unchanged.
REQ-016 ONE, i_pulse=0, counter == WINDOW-1: go to IDLE, assert o_single for one cycle, o_code <= 01.
REQ-017 TWO, i_pulse=0, counter == WINDOW-1: go to IDLE, assert o_double for one cycle, o_code <= 10.
REQ-018 Timing: for a click sampled at edge t with no further click, the decode output SHALL be high during the cycle after edge t+WINDOW.
REQ-019 Simultaneous expiry and click (i_pulse=1 at the edge where counter == WINDOW-1) SHALL be treated as a click per REQ-013/014; no timeout output in that cycle.
REQ-020 o_single, o_double and o_triple SHALL be registered, mutually exclusive, and each high for exactly one cycle per event.
REQ-021 A click in IDLE on the cycle immediately after any decode output SHALL start a new sequence with no loss.
REQ-022 i_pulse held high for N consecutive cycles SHALL be treated as N clicks.
REQ-023 o_busy SHALL be a combinational decode of state (ONE or TWO); o_code SHALL change only on decode events.
REQ-024 IDLE, i_pulse=0: counter holds 0, no outputs.

Reset
REQ-025 While i_reset=1: state IDLE, counter 0, o_single/o_double/o_triple 0, o_code 00, o_busy 0, with no dependence on i_clk.
REQ-026 Reset asserted mid-sequence (ONE or TWO) SHALL abort the sequence with no decode pulse, during reset or after release.
REQ-027 First edge after reset release SHALL accept i_pulse normally.

Verification (WINDOW=10)
REQ-028 Reset, then pulse at edge 5, none after -> o_single high only in the cycle after edge 15; o_code=01; o_busy high between edges 5 and 15.
REQ-029 Pulses at edges 5 and 12 -> o_double high only in the cycle after edge 22; o_code=10; no o_single.
REQ-030 Pulses at edges 5, 8, 11 -> o_triple high in the cycle after edge 11; o_code=11; o_busy low after edge 11; no timeout pulse follows.
REQ-031 Pulses at edges 5 and 15 (boundary) -> no o_single; o_double high in the cycle after edge 25.
REQ-032 Pulse at edge 5, i_reset asserted asynchronously between edges 9 and 10 and released before edge 11 -> outputs 0, o_code=00, no pulse through edge 30.
REQ-033 i_pulse held high for edges 5..7 -> o_triple high in the cycle after edge 7; an extra pulse at edge 8 starts a new sequence that decodes o_single in the cycle after edge 18.
